// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiplier issue/capture controller and its core.
package mul_issue_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RUN     = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_OUT     = 3'd4
   } state_t;

   localparam int MUL_STEPS = 8;
   localparam int STEP_W    = $clog2(MUL_STEPS);

endpackage

// File: rtl/mul_issue_ctrl_multiplier.sv
// Radix-2 Booth multiplier core, 8x8 signed -> 16-bit product.
// Reloads while Start is high and steps once per clock while Start is low.
// It never stops on its own: it keeps shifting past the 8th step, and Busy
// drops one step before the product is complete, so callers time it externally.
module Multiplier
   import mul_issue_ctrl_pkg::*;
(
   input  logic        CLK,
   input  logic        Start,
   input  logic [7:0]  Multiplicand,
   input  logic [7:0]  Multiplier,
   output logic        Busy,
   output logic [15:0] Product
);

   // Upper half carries two guard bits so A - M cannot overflow for -128 operands.
   logic signed [9:0] a_q, a_d, m_q, m_d, sum;
   logic [7:0]        q_q, q_d;
   logic              q1_q, q1_d;
   logic [3:0]        cnt_q, cnt_d;

   // Booth add/subtract followed by arithmetic shift of {A, Q, Q-1}.
   always_comb begin
      a_d   = a_q;
      m_d   = m_q;
      q_d   = q_q;
      q1_d  = q1_q;
      cnt_d = cnt_q;
      sum   = a_q;
      if (Start) begin
         a_d   = '0;
         m_d   = 10'($signed(Multiplicand));
         q_d   = Multiplier;
         q1_d  = 1'b0;
         cnt_d = '0;
      end else begin
         case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
         endcase
         {a_d, q_d, q1_d} = {sum[9], sum, q_q};
         if (cnt_q != 4'(MUL_STEPS)) cnt_d = cnt_q + 4'd1;
      end
   end

   // Core datapath registers.
   always_ff @(posedge CLK) begin
      a_q   <= a_d;
      m_q   <= m_d;
      q_q   <= q_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
   end

   assign Busy    = (cnt_q < 4'(MUL_STEPS - 1));
   assign Product = {a_q[7:0], q_q};

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/capture controller wrapped around the Booth multiplier core.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | InReady high, waiting for an operand pair
//   LOAD    | core Start high, core loads OpA/OpB at the next edge
//   RUN     | core Start low for exactly MUL_STEPS cycles
//   CAPTURE | Product valid; accumulate and register the result
//   OUT     | OutValid high, result held until OutReady
module mul_issue_ctrl
   import mul_issue_ctrl_pkg::*;
#(
   parameter int ACC_W = 24
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             InValid,
   output logic             InReady,
   input  logic [7:0]       InA,
   input  logic [7:0]       InB,
   input  logic             InAcc,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [ACC_W-1:0] OutResult,
   output logic             OutOverflow
);

   state_t             state_q, state_d;
   logic [STEP_W-1:0]  cnt_q, cnt_d;
   logic [7:0]         op_a_q, op_a_d, op_b_q, op_b_d;
   logic               acc_sel_q, acc_sel_d;
   logic [ACC_W-1:0]   acc_q, acc_d, result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               start;
   logic [15:0]        product;
   logic [ACC_W-1:0]   p_ext, addend, sum;

   // Core keeps reloading in every state except RUN, so it never free-runs while idle.
   Multiplier u_core (
      .CLK          (CLK),
      .Start        (start),
      .Multiplicand (op_a_q),
      .Multiplier   (op_b_q),
      .Busy         (),
      .Product      (product)
   );

   assign p_ext  = ACC_W'($signed(product));
   assign addend = acc_sel_q ? acc_q : '0;
   assign sum    = addend + p_ext;

   // Next-state, step counter, operand latch and accumulate-on-capture.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      acc_sel_d = acc_sel_q;
      acc_d     = acc_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      start     = 1'b1;
      InReady   = 1'b0;
      OutValid  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            InReady = 1'b1;
            if (InValid) begin
               op_a_d    = InA;
               op_b_d    = InB;
               acc_sel_d = InAcc;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            start = 1'b0;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == STEP_W'(MUL_STEPS - 1)) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            acc_d    = sum;
            result_d = sum;
            ovf_d    = (addend[ACC_W-1] == p_ext[ACC_W-1]) &&
                       (sum[ACC_W-1] != addend[ACC_W-1]);
            state_d  = ST_OUT;
         end
         ST_OUT: begin
            OutValid = 1'b1;
            if (OutReady) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and accumulator registers; reset discards any in-flight operation.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         acc_sel_q <= 1'b0;
         acc_q     <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         acc_sel_q <= acc_sel_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
      end
   end

   assign OutResult   = result_q;
   assign OutOverflow = ovf_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a 24-bit and a 17-bit instance driven in lockstep,
// checked against an arithmetic model of signed multiply-accumulate.
module tb_mul_issue_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        InValid, InAcc, OutReady;
   logic [7:0]  InA, InB;
   logic        InReady, OutValid, OutOverflow;
   logic [23:0] OutResult;
   logic        in_ready17, out_valid17, out_ovf17;
   logic [16:0] out_result17;

   int     checks = 0;
   int     errors = 0;
   longint acc24 = 0, acc17 = 0;
   longint exp24, exp17;
   bit     eovf24, eovf17;

   always #5 CLK = ~CLK;

   mul_issue_ctrl dut (
      .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady),
      .InA(InA), .InB(InB), .InAcc(InAcc), .OutValid(OutValid),
      .OutReady(OutReady), .OutResult(OutResult), .OutOverflow(OutOverflow)
   );

   mul_issue_ctrl #(.ACC_W(17)) dut17 (
      .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(in_ready17),
      .InA(InA), .InB(InB), .InAcc(InAcc), .OutValid(out_valid17),
      .OutReady(OutReady), .OutResult(out_result17), .OutOverflow(out_ovf17)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Signed wrap of an exact integer into a w-bit two's complement value.
   function automatic longint wrap(input longint v, input int w);
      longint m;
      m = v & ((longint'(1) << w) - 1);
      if (m >= (longint'(1) << (w - 1))) m -= (longint'(1) << w);
      return m;
   endfunction

   function automatic bit out_of_range(input longint v, input int w);
      return (v > ((longint'(1) << (w - 1)) - 1)) || (v < -(longint'(1) << (w - 1)));
   endfunction

   task automatic model_op(input int a, input int b, input bit sel);
      longint p, t24, t17;
      p      = longint'(a) * longint'(b);
      t24    = (sel ? acc24 : 0) + p;
      t17    = (sel ? acc17 : 0) + p;
      eovf24 = out_of_range(t24, 24);
      eovf17 = out_of_range(t17, 17);
      acc24  = wrap(t24, 24);
      acc17  = wrap(t17, 17);
      exp24  = acc24 & 64'hFF_FFFF;
      exp17  = acc17 & 64'h1_FFFF;
   endtask

   task automatic accept(input int a, input int b, input bit sel);
      int w;
      w = 0;
      while (!InReady && w < 30) begin
         @(negedge CLK);
         w++;
      end
      check("in_ready_idle", {63'd0, InReady}, 64'd1);
      InValid  = 1'b1;
      InA      = 8'(a);
      InB      = 8'(b);
      InAcc    = sel;
      OutReady = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      InValid = 1'b0;
      InA     = 8'($urandom);
      InB     = 8'($urandom);
      InAcc   = 1'($urandom);
   endtask

   task automatic run_op(input int a, input int b, input bit sel, input int hold, input bit pulse);
      int          lat;
      logic [23:0] r24;
      logic [16:0] r17;
      accept(a, b, sel);
      model_op(a, b, sel);
      lat = 0;
      while (!OutValid && lat < 30) begin
         @(posedge CLK);
         lat++;
         @(negedge CLK);
      end
      check("latency", 64'(lat), 64'd10);
      check("out_valid17", {63'd0, out_valid17}, 64'd1);
      check("result24", {40'd0, OutResult}, exp24);
      check("ovf24", {63'd0, OutOverflow}, {63'd0, eovf24});
      check("result17", {47'd0, out_result17}, exp17);
      check("ovf17", {63'd0, out_ovf17}, {63'd0, eovf17});
      r24 = OutResult;
      r17 = out_result17;
      for (int i = 0; i < hold; i++) begin
         if (pulse && i == 1) begin
            InValid = 1'b1;
            InA     = 8'd9;
            InB     = 8'd9;
         end
         @(posedge CLK);
         @(negedge CLK);
         InValid = 1'b0;
         check("hold_valid", {63'd0, OutValid}, 64'd1);
         check("hold_in_ready", {63'd0, InReady}, 64'd0);
         check("hold_result24", {40'd0, OutResult}, {40'd0, r24});
         check("hold_result17", {47'd0, out_result17}, {47'd0, r17});
      end
      OutReady = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      OutReady = 1'b0;
      check("valid_after_hs", {63'd0, OutValid}, 64'd0);
      check("ready_after_hs", {63'd0, InReady}, 64'd1);
   endtask

   initial begin
      byte sa, sb;
      RST      = 1'b1;
      InValid  = 1'b0;
      InA      = '0;
      InB      = '0;
      InAcc    = 1'b0;
      OutReady = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      check("rst_in_ready", {63'd0, InReady}, 64'd1);
      check("rst_out_valid", {63'd0, OutValid}, 64'd0);
      check("rst_result", {40'd0, OutResult}, 64'd0);
      check("rst_ovf", {63'd0, OutOverflow}, 64'd0);
      check("rst_result17", {47'd0, out_result17}, 64'd0);

      run_op(3, 5, 1'b0, 0, 1'b0);
      check("r_3x5", {40'd0, OutResult}, 64'd15);
      run_op(-7, 6, 1'b0, 0, 1'b0);
      check("r_m7x6", {40'd0, OutResult}, 64'hFFFFD6);
      run_op(10, 10, 1'b0, 0, 1'b0);
      check("r_10x10", {40'd0, OutResult}, 64'd100);
      run_op(20, 20, 1'b1, 0, 1'b0);
      check("r_acc500", {40'd0, OutResult}, 64'h1F4);

      run_op(-128, -128, 1'b0, 5, 1'b1);
      check("r_m128sq", {40'd0, OutResult}, 64'd16384);
      run_op(-128, -128, 1'b1, 0, 1'b0);
      check("r17_2", {47'd0, out_result17}, 64'h08000);
      run_op(-128, -128, 1'b1, 0, 1'b0);
      check("r17_3", {47'd0, out_result17}, 64'h0C000);
      check("ovf17_3", {63'd0, out_ovf17}, 64'd0);
      run_op(-128, -128, 1'b1, 0, 1'b0);
      check("r17_4", {47'd0, out_result17}, 64'h10000);
      check("ovf17_4", {63'd0, out_ovf17}, 64'd1);
      check("ovf24_4", {63'd0, OutOverflow}, 64'd0);

      accept(50, 50, 1'b0);
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RST   = 1'b0;
      acc24 = 0;
      acc17 = 0;
      check("midrun_rst_valid", {63'd0, OutValid}, 64'd0);
      check("midrun_rst_ready", {63'd0, InReady}, 64'd1);
      check("midrun_rst_result", {40'd0, OutResult}, 64'd0);
      run_op(2, 2, 1'b1, 0, 1'b0);
      check("post_rst_acc", {40'd0, OutResult}, 64'd4);

      for (int n = 0; n < 40; n++) begin
         sa = byte'($urandom);
         sb = byte'($urandom);
         if ($urandom_range(0, 3) == 0) sa = -8'sd128;
         if ($urandom_range(0, 3) == 0) sb = -8'sd128;
         run_op(int'(sa), int'(sb), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
